// File: rtl/match_scan_ctrl_if.sv
// Bundle between the scan controller, its host, the lock-word BRAM and the external match comparator.
interface match_scan_ctrl_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 6
);
  logic              start;
  logic [WIDTH-1:0]  key;
  logic [ADDR_W:0]   len;
  logic              busy;
  logic              done;
  logic              hit;
  logic [ADDR_W-1:0] hit_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_dout;
  logic [WIDTH-1:0]  cmp_lock;
  logic [WIDTH-1:0]  cmp_key;
  logic              cmp_match;

  // Controller side
  modport slave (
    input  start, key, len, mem_dout, cmp_match,
    output busy, done, hit, hit_addr, mem_en, mem_addr, cmp_lock, cmp_key
  );

  // Host / memory / comparator side
  modport master (
    output start, key, len, mem_dout, cmp_match,
    input  busy, done, hit, hit_addr, mem_en, mem_addr, cmp_lock, cmp_key
  );
endinterface

// File: rtl/match_scan_ctrl.sv
// Streams table addresses into a 1-cycle BRAM and reports the lowest address whose
// lock word matches the latched key, as judged by an external comparator.
module match_scan_ctrl #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  match_scan_ctrl_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FIN} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_key;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_ra;
  logic [LEN_W-1:0]  r_ca;
  logic              r_vld;
  logic              r_busy;
  logic              r_done;
  logic              r_hit;
  logic [ADDR_W-1:0] r_hit_addr;
  logic              r_mem_en;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [LEN_W-1:0]  w_len_in;
  logic              w_last;

  // Oversized lengths are clamped so the issue counter can never leave the table
  assign w_len_in = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;
  assign w_last   = (r_ca == (r_len - LEN_W'(1)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_len      <= '0;
      r_ra       <= '0;
      r_ca       <= '0;
      r_vld      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_hit      <= 1'b0;
      r_hit_addr <= '0;
      r_mem_en   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_vld    <= 1'b0;
          r_mem_en <= 1'b0;
          if (bus.start) begin
            r_key      <= bus.key;
            r_len      <= w_len_in;
            r_busy     <= 1'b1;
            r_ra       <= LEN_W'(1);
            r_mem_addr <= '0;
            if (w_len_in == '0) begin
              r_state    <= S_FIN;
              r_done     <= 1'b1;
              r_hit      <= 1'b0;
              r_hit_addr <= '0;
            end else begin
              // Address 0 goes out in the first SCAN cycle
              r_state  <= S_SCAN;
              r_mem_en <= 1'b1;
            end
          end
        end

        S_SCAN: begin
          r_vld <= r_mem_en;
          r_ca  <= LEN_W'(r_mem_addr);
          if (r_ra < r_len) begin
            r_mem_en   <= 1'b1;
            r_mem_addr <= ADDR_W'(r_ra);
            r_ra       <= r_ra + LEN_W'(1);
          end else begin
            r_mem_en <= 1'b0;
          end
          // Data arrives in address order, so the first match seen is the lowest
          if (r_vld && bus.cmp_match) begin
            r_state    <= S_FIN;
            r_done     <= 1'b1;
            r_hit      <= 1'b1;
            r_hit_addr <= ADDR_W'(r_ca);
            r_mem_en   <= 1'b0;
          end else if (r_vld && w_last) begin
            r_state    <= S_FIN;
            r_done     <= 1'b1;
            r_hit      <= 1'b0;
            r_hit_addr <= '0;
            r_mem_en   <= 1'b0;
          end
        end

        S_FIN: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_vld    <= 1'b0;
          r_mem_en <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_done   <= 1'b0;
          r_busy   <= 1'b0;
          r_vld    <= 1'b0;
          r_mem_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.hit      = r_hit;
  assign bus.hit_addr = r_hit_addr;
  assign bus.mem_en   = r_mem_en;
  assign bus.mem_addr = r_mem_addr;
  assign bus.cmp_lock = bus.mem_dout;
  assign bus.cmp_key  = r_key;

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Scoreboard bench: a BRAM and comparator model around match_scan_ctrl, expected results queued at start.
module tb_match_scan_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  match_scan_ctrl_if #(.WIDTH(16), .ADDR_W(6)) bus ();

  match_scan_ctrl #(.WIDTH(16), .DEPTH(64), .ADDR_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       hit;
    logic [5:0] addr;
    int         cyc;
    int         max_lo;
    int         max_hi;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] tbl [64];
  int          total = 0;
  int          bad = 0;
  int          max_addr = -1;
  int          oob = 0;
  int          nreads = 0;
  int          cur_len = 0;

  // BRAM with 1-cycle read latency and the external comparator
  always_ff @(posedge clk) begin
    if (bus.mem_en) bus.mem_dout <= tbl[bus.mem_addr];
  end
  assign bus.cmp_match = (bus.cmp_lock == bus.cmp_key);

  always @(negedge clk) begin
    if (bus.mem_en) begin
      nreads = nreads + 1;
      if (int'(bus.mem_addr) >= cur_len) oob = oob + 1;
      if (int'(bus.mem_addr) > max_addr) max_addr = int'(bus.mem_addr);
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    total = total + 1;
    if (got != exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] k, input int l);
    exp_t e;
    e.hit    = 1'b0;
    e.addr   = 6'd0;
    e.cyc    = (l == 0) ? 1 : l + 2;
    e.max_lo = l - 1;
    e.max_hi = l - 1;
    for (int i = 0; i < l; i++) begin
      if (tbl[i] == k) begin
        e.hit    = 1'b1;
        e.addr   = 6'(i);
        e.cyc    = i + 3;
        e.max_lo = i;
        e.max_hi = (i + 1 < l) ? i + 1 : l - 1;
        break;
      end
    end
    return e;
  endfunction

  // One scan; dist_cyc>0 pulses a stray start mid-scan, poke raises start during done
  task automatic run_scan(input logic [15:0] k, input int l, input int dist_cyc,
                          input logic [15:0] dkey, input bit poke);
    exp_t e;
    int   c;
    @(negedge clk);
    bus.key   = k;
    bus.len   = 7'(l);
    bus.start = 1'b1;
    sb.push_back(model(k, l));
    cur_len = l;
    @(posedge clk);
    max_addr = -1;
    oob      = 0;
    nreads   = 0;
    @(negedge clk);
    bus.start = 1'b0;
    bus.key   = ~k;
    bus.len   = 7'd1;
    c = 1;
    while (!bus.done && c < 200) begin
      if (c == dist_cyc) begin
        bus.start = 1'b1;
        bus.key   = dkey;
        bus.len   = 7'd64;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      c = c + 1;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    chk("done_seen", int'(bus.done), 1);
    chk("done_cyc", c, e.cyc);
    chk("hit", int'(bus.hit), int'(e.hit));
    chk("hit_addr", int'(bus.hit_addr), int'(e.addr));
    chk("busy_at_done", int'(bus.busy), 1);
    chk("mem_en_at_done", int'(bus.mem_en), 0);
    chk("read_oob", oob, 0);
    if (e.max_hi >= 0) begin
      chk("max_addr_lo", int'(max_addr >= e.max_lo), 1);
      chk("max_addr_hi", int'(max_addr <= e.max_hi), 1);
    end else begin
      chk("nreads", nreads, 0);
    end
    if (poke) begin
      bus.start = 1'b1;
      bus.key   = dkey;
      bus.len   = 7'd64;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_on_done_busy", int'(bus.busy), 0);
      chk("start_on_done_pulse", int'(bus.done), 0);
    end
  endtask

  initial begin
    int nd;
    bus.start = 1'b0;
    bus.key   = '0;
    bus.len   = '0;
    for (int k = 0; k < 64; k++) tbl[k] = 16'(k * 3);
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_hit", int'(bus.hit), 0);
    chk("rst_hit_addr", int'(bus.hit_addr), 0);
    chk("rst_mem_en", int'(bus.mem_en), 0);
    chk("rst_mem_addr", int'(bus.mem_addr), 0);
    chk("rst_cmp_key", int'(bus.cmp_key), 0);
    rst = 1'b0;

    run_scan(16'h0015, 64, 0, 16'h0, 1'b0);
    run_scan(16'hFFFF, 64, 0, 16'h0, 1'b0);
    chk("miss_max_addr", max_addr, 63);
    tbl[5]  = 16'hABCD;
    tbl[20] = 16'hABCD;
    run_scan(16'hABCD, 64, 0, 16'h0, 1'b0);
    run_scan(16'h0015, 0, 0, 16'h0, 1'b0);
    tbl[12] = 16'h1234;
    run_scan(16'h1234, 10, 0, 16'h0, 1'b0);
    chk("short_max_addr", max_addr, 9);
    run_scan(16'h1234, 64, 0, 16'h0, 1'b0);
    run_scan(16'h0015, 64, 3, 16'h0000, 1'b0);
    run_scan(16'hABCD, 64, 0, 16'h0, 1'b1);

    // Abandon a scan with a reset in cycle 4
    @(negedge clk);
    bus.key   = 16'h0015;
    bus.len   = 7'd64;
    bus.start = 1'b1;
    cur_len   = 64;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_mem_en", int'(bus.mem_en), 0);
    chk("midrst_hit", int'(bus.hit), 0);
    chk("midrst_hit_addr", int'(bus.hit_addr), 0);
    chk("midrst_done", int'(bus.done), 0);
    nd = 0;
    repeat (80) begin
      @(negedge clk);
      if (bus.done) nd = nd + 1;
    end
    chk("midrst_no_done", nd, 0);

    run_scan(16'h1234, 64, 0, 16'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
